branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Parametrised successor to the fetch/branch resolution path. Adds a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters.
- Fetch side: combinational prediction for the current fetch PC.
- Execute side: resolves the branch (compare + target adder), detects mispredicts, issues a registered redirect, updates the tables and keeps statistics counters.

Parameters:
- WORD_W, 32, datapath/PC width
- BTB_ENTRIES, 16, BTB depth; power of two, >= 2; IDX_W = $clog2(BTB_ENTRIES)
- CTR_W, 2, direction counter width; predict taken when MSB = 1
- STAT_W, 32, statistics counter width

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- fetch_pc  in  WORD_W  PC being fetched
- pred_hit  out  1  BTB valid entry with tag match
- pred_taken  out  1  pred_hit AND counter MSB
- pred_target  out  WORD_W  stored target (0 when no hit)
- res_valid  in  1  conditional branch resolving this cycle
- res_branch_type  in  2  00 BEQ, 01 BNE, 10 BLT signed, 11 BGE signed
- res_reg_a, res_reg_b  in  WORD_W  compare operands
- res_pc  in  WORD_W  PC of the branch
- res_imm  in  WORD_W  sign-extended byte offset
- res_pred_taken  in  1  prediction carried down the pipe
- res_pred_target  in  WORD_W  predicted target carried down the pipe
- branch_outcome  out  1  registered resolved direction
- mispredict  out  1  registered one-cycle pulse
- redirect_pc  out  WORD_W  registered correct next PC
- stat_branches  out  STAT_W  resolved branches
- stat_mispredicts  out  STAT_W  mispredicts

Behaviour:
- **Index/tag:** idx = pc[IDX_W+1:2]; tag = pc[WORD_W-1:IDX_W+2]; pc[1:0] ignored.
- **Entry state:** valid, tag, target, counter.
- **Prediction:** purely combinational from current table state, zero latency. No bypass: a same-cycle update to the same index is visible next cycle.
- **Resolution (combinational, when res_valid):**
  - taken = compare per res_branch_type; BLT/BGE use signed compare.
  - target = res_pc + res_imm; fallthrough = res_pc + 4; both wrap modulo 2^WORD_W.
  - mis = (taken != res_pred_taken) OR (taken AND res_pred_target != target).
- **Registered outputs (one cycle after the res_valid edge):**
  - branch_outcome <= taken.
  - mispredict <= mis.
  - redirect_pc <= taken ? target : fallthrough.
  - With res_valid = 0: mispredict <= 0; branch_outcome and redirect_pc hold.
- **Table update, same edge as res_valid; hit recomputed for res_pc:**
  - Hit: counter +1 if taken, -1 if not, saturating at 0 and 2^CTR_W-1. Target overwritten with the computed target when taken.
  - Miss and taken: allocate (overwrite any aliased entry). valid = 1, tag, target, counter = 2^(CTR_W-1) (weakly taken).
  - Miss and not taken: no change.
- **Statistics:** stat_branches +1 per res_valid; stat_mispredicts +1 when mis. Both saturate at all-ones, no wrap.
- **Concurrency:** fetch lookup and resolve update may target the same index in the same cycle; the lookup returns the old value.
- **Reset (synchronous, overrides everything, including mid-resolution):**
  - All valid = 0; counters = 2^(CTR_W-1)-1 (weakly not taken); targets/tags = 0.
  - branch_outcome, mispredict, redirect_pc = 0; stats = 0.
  - Hence pred_hit/pred_taken = 0 and pred_target = 0 in the cycle after reset.
- **Latency:** prediction 0 cycles; mispredict/redirect 1 cycle; table effects visible at fetch 1 cycle after the res_valid edge.

Test Plan:
- **Reset:** assert RST 2 cycles with res_valid = 1 -> all outputs 0; pred_hit = 0 for fetch_pc = 0x100; stats 0.
- **Cold taken BEQ:** res_pc = 0x100, imm = 0x40, a = b = 5, res_pred_taken = 0 -> next cycle mispredict = 1, redirect_pc = 0x140, branch_outcome = 1. Then fetch_pc = 0x100 -> pred_hit = 1, pred_taken = 1, pred_target = 0x140; mispredict returns to 0 the following cycle.
- **Counter saturation:** 4 taken resolves at 0x100 -> counter 3. Then 1 not-taken -> pred_taken still 1. Second not-taken -> pred_taken = 0.
- **Signed compare:** BLT, a = 0xFFFFFFFF, b = 1, imm = -8, pc = 0x200 -> taken, redirect_pc = 0x1F8. BGE with the same operands -> not taken, redirect_pc = 0x204, no allocation.
- **Aliasing:** entry allocated for 0x100; resolve taken at 0x100 + 4*BTB_ENTRIES -> same index, tag replaced. fetch_pc = 0x100 -> pred_hit = 0.
- **Stats saturation (STAT_W = 4):** 20 mispredicting resolves -> stat_branches = stat_mispredicts = 15. Same-cycle fetch/update to the same index -> old prediction returned.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Branch predictor: direct-mapped BTB with saturating direction counters, plus branch resolution.
// Latency: prediction is combinational (0 cycles); mispredict/redirect/outcome are registered (1 cycle).
// Backpressure: none; a resolve is accepted every cycle res_valid is high, fetch lookup is always available.
module branch_predict_unit #(
  parameter int WORD_W      = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int CTR_W       = 2,
  parameter int STAT_W      = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] fetch_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [WORD_W-1:0] pred_target,
  input  logic              res_valid,
  input  logic [1:0]        res_branch_type,
  input  logic [WORD_W-1:0] res_reg_a,
  input  logic [WORD_W-1:0] res_reg_b,
  input  logic [WORD_W-1:0] res_pc,
  input  logic [WORD_W-1:0] res_imm,
  input  logic              res_pred_taken,
  input  logic [WORD_W-1:0] res_pred_target,
  output logic              branch_outcome,
  output logic              mispredict,
  output logic [WORD_W-1:0] redirect_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = WORD_W - IDX_W - 2;

  localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_ONE << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_ONE;
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

  localparam logic [1:0] BT_BEQ = 2'b00;
  localparam logic [1:0] BT_BNE = 2'b01;
  localparam logic [1:0] BT_BLT = 2'b10;

  // BTB storage
  logic              valid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0]  tag_q    [BTB_ENTRIES];
  logic [WORD_W-1:0] target_q [BTB_ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [BTB_ENTRIES];

  // Registered resolution results and statistics
  logic              outcome_q, outcome_d;
  logic              mis_q, mis_d;
  logic [WORD_W-1:0] redirect_q, redirect_d;
  logic [STAT_W-1:0] br_cnt_q, br_cnt_d;
  logic [STAT_W-1:0] mp_cnt_q, mp_cnt_d;

  // Fetch-side lookup fields; the two byte-offset bits never take part
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             unused_fetch_lsb;
  assign f_idx            = fetch_pc[IDX_W+1:2];
  assign f_tag            = fetch_pc[WORD_W-1:IDX_W+2];
  assign unused_fetch_lsb = ^fetch_pc[1:0];

  // Resolve-side fields
  logic [IDX_W-1:0]  r_idx;
  logic [TAG_W-1:0]  r_tag;
  logic              r_hit;
  logic              res_taken;
  logic              res_mis;
  logic [WORD_W-1:0] res_target;
  logic [WORD_W-1:0] res_fall;
  assign r_idx      = res_pc[IDX_W+1:2];
  assign r_tag      = res_pc[WORD_W-1:IDX_W+2];
  assign r_hit      = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
  assign res_target = res_pc + res_imm;
  assign res_fall   = res_pc + WORD_W'(4);

  // Next-state of the single entry a resolve may touch
  logic              ent_we;
  logic [TAG_W-1:0]  ent_tag_d;
  logic [WORD_W-1:0] ent_target_d;
  logic [CTR_W-1:0]  ent_ctr_d;

  // Zero-latency prediction straight from the table; same-cycle updates are not bypassed
  always_comb begin
    pred_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken  = pred_hit && ctr_q[f_idx][CTR_W-1];
    pred_target = pred_hit ? target_q[f_idx] : '0;
  end

  // Branch condition evaluation and mispredict detection
  always_comb begin
    res_taken = 1'b0;
    case (res_branch_type)
      BT_BEQ:  res_taken = (res_reg_a == res_reg_b);
      BT_BNE:  res_taken = (res_reg_a != res_reg_b);
      BT_BLT:  res_taken = ($signed(res_reg_a) < $signed(res_reg_b));
      default: res_taken = ($signed(res_reg_a) >= $signed(res_reg_b));
    endcase
    res_mis = (res_taken != res_pred_taken) ||
              (res_taken && (res_pred_target != res_target));
  end

  // Entry update: train on a hit, allocate only on a taken miss
  always_comb begin
    ent_we       = 1'b0;
    ent_tag_d    = tag_q[r_idx];
    ent_target_d = target_q[r_idx];
    ent_ctr_d    = ctr_q[r_idx];
    if (res_valid) begin
      if (r_hit) begin
        ent_we = 1'b1;
        if (res_taken) begin
          ent_target_d = res_target;
          if (ctr_q[r_idx] != CTR_MAX) ent_ctr_d = ctr_q[r_idx] + CTR_ONE;
        end else if (ctr_q[r_idx] != '0) begin
          ent_ctr_d = ctr_q[r_idx] - CTR_ONE;
        end
      end else if (res_taken) begin
        ent_we       = 1'b1;
        ent_tag_d    = r_tag;
        ent_target_d = res_target;
        ent_ctr_d    = CTR_WT;
      end
    end
  end

  // Redirect/outcome hold when idle, mispredict is a single-cycle pulse; stats saturate
  always_comb begin
    outcome_d  = outcome_q;
    redirect_d = redirect_q;
    mis_d      = 1'b0;
    br_cnt_d   = br_cnt_q;
    mp_cnt_d   = mp_cnt_q;
    if (res_valid) begin
      outcome_d  = res_taken;
      redirect_d = res_taken ? res_target : res_fall;
      mis_d      = res_mis;
      if (br_cnt_q != '1) br_cnt_d = br_cnt_q + STAT_ONE;
      if (res_mis && (mp_cnt_q != '1)) mp_cnt_d = mp_cnt_q + STAT_ONE;
    end
  end

  // BTB table state; reset clears every entry to invalid / weakly not taken
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (ent_we) begin
      valid_q[r_idx]  <= 1'b1;
      tag_q[r_idx]    <= ent_tag_d;
      target_q[r_idx] <= ent_target_d;
      ctr_q[r_idx]    <= ent_ctr_d;
    end
  end

  // Resolution result and statistics registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      outcome_q  <= 1'b0;
      mis_q      <= 1'b0;
      redirect_q <= '0;
      br_cnt_q   <= '0;
      mp_cnt_q   <= '0;
    end else begin
      outcome_q  <= outcome_d;
      mis_q      <= mis_d;
      redirect_q <= redirect_d;
      br_cnt_q   <= br_cnt_d;
      mp_cnt_q   <= mp_cnt_d;
    end
  end

  assign branch_outcome   = outcome_q;
  assign mispredict       = mis_q;
  assign redirect_pc      = redirect_q;
  assign stat_branches    = br_cnt_q;
  assign stat_mispredicts = mp_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed scenarios then random resolves against a reference model.
// A second instance with 4-bit statistics shares all inputs to exercise counter saturation.
module tb_branch_predict_unit;

  localparam int NE = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] fetch_pc;
  logic        res_valid;
  logic [1:0]  res_branch_type;
  logic [31:0] res_reg_a, res_reg_b, res_pc, res_imm, res_pred_target;
  logic        res_pred_taken;

  logic        pred_hit, pred_taken, branch_outcome, mispredict;
  logic [31:0] pred_target, redirect_pc, stat_branches, stat_mispredicts;
  logic        s_hit, s_taken, s_outcome, s_mis;
  logic [31:0] s_target, s_redirect;
  logic [3:0]  s_branches, s_mispredicts;

  always #5 CLK = ~CLK;

  branch_predict_unit dut (
    .CLK(CLK), .RST(RST), .fetch_pc(fetch_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_branch_type(res_branch_type),
    .res_reg_a(res_reg_a), .res_reg_b(res_reg_b), .res_pc(res_pc), .res_imm(res_imm),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .branch_outcome(branch_outcome), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  branch_predict_unit #(.STAT_W(4)) dut_s (
    .CLK(CLK), .RST(RST), .fetch_pc(fetch_pc),
    .pred_hit(s_hit), .pred_taken(s_taken), .pred_target(s_target),
    .res_valid(res_valid), .res_branch_type(res_branch_type),
    .res_reg_a(res_reg_a), .res_reg_b(res_reg_b), .res_pc(res_pc), .res_imm(res_imm),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .branch_outcome(s_outcome), .mispredict(s_mis), .redirect_pc(s_redirect),
    .stat_branches(s_branches), .stat_mispredicts(s_mispredicts)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain table of entries with integer counters
  bit          m_v   [NE];
  logic [31:0] m_tag [NE];
  logic [31:0] m_tgt [NE];
  int          m_ctr [NE];
  logic        m_out, m_mis;
  logic [31:0] m_redir;
  longint      m_br, m_mp;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % NE);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_v[m_idx(pc)] && (m_tag[m_idx(pc)] == (pc >> 6));
  endfunction

  function automatic bit m_ptaken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptarget(input logic [31:0] pc);
    return m_hit(pc) ? m_tgt[m_idx(pc)] : 32'h0;
  endfunction

  function automatic bit m_cond(input logic [1:0] ty, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (ty)
      2'd0:    return a == b;
      2'd1:    return a != b;
      2'd2:    return sa < sb;
      default: return sa >= sb;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_v[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_out = 0; m_mis = 0; m_redir = '0; m_br = 0; m_mp = 0;
  endtask

  task automatic model_step();
    bit t, mis;
    int i;
    logic [31:0] tgt;
    if (RST) begin
      model_reset();
    end else if (res_valid) begin
      t   = m_cond(res_branch_type, res_reg_a, res_reg_b);
      tgt = res_pc + res_imm;
      mis = (t != res_pred_taken) || (t && (res_pred_target != tgt));
      m_out = t; m_mis = mis; m_redir = t ? tgt : res_pc + 32'd4;
      m_br++;
      if (mis) m_mp++;
      i = m_idx(res_pc);
      if (m_hit(res_pc)) begin
        m_ctr[i] = t ? ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1) : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
        if (t) m_tgt[i] = tgt;
      end else if (t) begin
        m_v[i] = 1'b1; m_tag[i] = res_pc >> 6; m_tgt[i] = tgt; m_ctr[i] = 2;
      end
    end else begin
      m_mis = 0;
    end
  endtask

  // One clock: prediction checked before the edge, registered results after it
  task automatic cycle();
    #1;
    check("pred_hit", pred_hit, m_hit(fetch_pc));
    check("pred_taken", pred_taken, m_ptaken(fetch_pc));
    check("pred_target", pred_target, m_ptarget(fetch_pc));
    check("s_pred_hit", s_hit, m_hit(fetch_pc));
    @(posedge CLK);
    model_step();
    #1;
    check("branch_outcome", branch_outcome, m_out);
    check("mispredict", mispredict, m_mis);
    check("redirect_pc", redirect_pc, m_redir);
    check("stat_branches", stat_branches, m_br);
    check("stat_mispredicts", stat_mispredicts, m_mp);
    check("s_redirect_pc", s_redirect, m_redir);
    check("s_stat_branches", s_branches, (m_br > 15) ? 15 : m_br);
    check("s_stat_mispredicts", s_mispredicts, (m_mp > 15) ? 15 : m_mp);
  endtask

  task automatic drive(input bit rst, input bit vld, input logic [1:0] ty,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                       input logic [31:0] imm, input bit pt, input logic [31:0] ptg,
                       input logic [31:0] fpc);
    RST = rst; res_valid = vld; res_branch_type = ty; res_reg_a = a; res_reg_b = b;
    res_pc = pc; res_imm = imm; res_pred_taken = pt; res_pred_target = ptg; fetch_pc = fpc;
    cycle();
  endtask

  task automatic resolve(input logic [1:0] ty, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm, input bit pt,
                         input logic [31:0] ptg);
    drive(1'b0, 1'b1, ty, a, b, pc, imm, pt, ptg, pc);
  endtask

  task automatic idle(input logic [31:0] fpc);
    drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, fpc);
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    model_reset();

    // Reset held two cycles with a live resolve
    drive(1'b1, 1'b1, 2'd0, 32'd5, 32'd5, 32'h100, 32'h40, 1'b0, 32'h0, 32'h100);
    drive(1'b1, 1'b1, 2'd0, 32'd5, 32'd5, 32'h100, 32'h40, 1'b0, 32'h0, 32'h100);
    check("rst_outcome", branch_outcome, 0);
    check("rst_mispredict", mispredict, 0);
    check("rst_redirect", redirect_pc, 0);
    check("rst_hit", pred_hit, 0);
    check("rst_stats", stat_branches, 0);

    // Cold taken BEQ
    resolve(2'd0, 32'd5, 32'd5, 32'h100, 32'h40, 1'b0, 32'h0);
    check("cold_mis", mispredict, 1);
    check("cold_redirect", redirect_pc, 32'h140);
    check("cold_outcome", branch_outcome, 1);
    idle(32'h100);
    check("cold_hit", pred_hit, 1);
    check("cold_ptaken", pred_taken, 1);
    check("cold_ptarget", pred_target, 32'h140);
    check("cold_mis_clear", mispredict, 0);

    // Counter saturation then two not-taken
    repeat (4) resolve(2'd0, 32'd5, 32'd5, 32'h100, 32'h40, 1'b1, 32'h140);
    resolve(2'd0, 32'd5, 32'd6, 32'h100, 32'h40, 1'b1, 32'h140);
    idle(32'h100);
    check("sat_nt1_ptaken", pred_taken, 1);
    resolve(2'd0, 32'd5, 32'd6, 32'h100, 32'h40, 1'b1, 32'h140);
    idle(32'h100);
    check("sat_nt2_ptaken", pred_taken, 0);

    // Signed compares
    resolve(2'd2, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'hFFFF_FFF8, 1'b0, 32'h0);
    check("blt_outcome", branch_outcome, 1);
    check("blt_redirect", redirect_pc, 32'h1F8);
    resolve(2'd3, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'hFFFF_FFF8, 1'b0, 32'h0);
    check("bge_outcome", branch_outcome, 0);
    check("bge_redirect", redirect_pc, 32'h204);
    resolve(2'd3, 32'hFFFF_FFFF, 32'd1, 32'h208, 32'hFFFF_FFF8, 1'b0, 32'h0);
    idle(32'h208);
    check("bge_no_alloc", pred_hit, 0);

    // Aliasing: same index, different tag
    resolve(2'd0, 32'd1, 32'd1, 32'h100, 32'h10, 1'b0, 32'h0);
    idle(32'h100);
    check("alias_first_hit", pred_hit, 1);
    resolve(2'd0, 32'd1, 32'd1, 32'h100 + 4 * NE, 32'h20, 1'b0, 32'h0);
    idle(32'h100);
    check("alias_old_gone", pred_hit, 0);
    idle(32'h100 + 4 * NE);
    check("alias_new_hit", pred_hit, 1);

    // Mispredict storm: saturates the 4-bit stats instance; first resolve is a same-cycle lookup
    repeat (20) resolve(2'd0, 32'd7, 32'd7, 32'h300, 32'h44, 1'b0, 32'h0);
    check("stat4_branches", s_branches, 15);
    check("stat4_mispredicts", s_mispredicts, 15);
    idle(32'h300);
    check("storm_hit", pred_hit, 1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc, imm, fpc, ptg;
      bit pt;
      pc  = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
      imm = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 63)) - 32'd32) << 2;
      fpc = ($urandom_range(0, 1) == 0) ? pc
            : (($urandom_range(0, 3) << 12) | ($urandom_range(0, 31) << 2));
      pt  = ($urandom_range(0, 1) == 0) ? m_ptaken(pc) : 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       ptg = m_ptarget(pc);
        1:       ptg = pc + imm;
        default: ptg = $urandom;
      endcase
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)),
            pick_op(), pick_op(), pc, imm, pt, ptg, fpc);
    end

    // Final reset clears everything
    drive(1'b1, 1'b1, 2'd0, 32'd1, 32'd1, 32'h300, 32'h8, 1'b0, 32'h0, 32'h300);
    check("final_rst_hit", pred_hit, 0);
    check("final_rst_stats", stat_mispredicts, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
